// File: rtl/universal_shift_register.sv
// universal_shift_register
//   Parametrised N-bit universal shift register with single-step operations
//   (shift, rotate, arithmetic shift, load) and a burst engine. The burst
//   engine repeats a shift/rotate a programmable number of times, one position
//   per cycle, with a busy/done handshake and an abort.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   en        single-step enable (IDLE only)
//   mode      000 hold, 001 SRL, 010 SLL, 011 ROR, 100 ROL, 101 SRA,
//             110 LOAD, 111 hold (reserved)
//   d_in      parallel load data
//   ser_in_r  bit entering the MSB on SRL
//   ser_in_l  bit entering the LSB on SLL
//   start     begin burst (IDLE only)
//   amt       burst step count, sampled with start
//   abort     terminate a burst in progress
//   q_out     register contents
//   ser_out   bit expelled by the most recent step
//   busy      burst in progress
//   done      one-cycle burst completion pulse
module universal_shift_register #(
  parameter int N  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  d_in,
  input  logic          ser_in_r,
  input  logic          ser_in_l,
  input  logic          start,
  input  logic [AW-1:0] amt,
  input  logic          abort,
  output logic [N-1:0]  q_out,
  output logic          ser_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SRL  = 3'b001,
    M_SLL  = 3'b010,
    M_ROR  = 3'b011,
    M_ROL  = 3'b100,
    M_SRA  = 3'b101,
    M_LOAD = 3'b110,
    M_RSVD = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e        state;
  mode_e         burst_mode;
  logic [AW-1:0] cnt;

  mode_e         op_mode;
  logic          is_shift;
  logic [N-1:0]  q_nxt;
  logic          so_nxt;

  // In a burst the latched mode drives the step logic; mode input is ignored.
  always_comb begin
    op_mode  = (state == SHIFT) ? burst_mode : mode_e'(mode);
    is_shift = (mode >= 3'd1) && (mode <= 3'd5);
  end

  always_comb begin
    q_nxt  = q_out;
    so_nxt = ser_out;
    case (op_mode)
      M_SRL: begin
        q_nxt  = {ser_in_r, q_out[N-1:1]};
        so_nxt = q_out[0];
      end
      M_SLL: begin
        q_nxt  = {q_out[N-2:0], ser_in_l};
        so_nxt = q_out[N-1];
      end
      M_ROR: begin
        q_nxt  = {q_out[0], q_out[N-1:1]};
        so_nxt = q_out[0];
      end
      M_ROL: begin
        q_nxt  = {q_out[N-2:0], q_out[N-1]};
        so_nxt = q_out[N-1];
      end
      M_SRA: begin
        q_nxt  = {q_out[N-1], q_out[N-1:1]};
        so_nxt = q_out[0];
      end
      M_LOAD: begin
        q_nxt  = d_in;
      end
      default: begin
        q_nxt  = q_out;
        so_nxt = ser_out;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      burst_mode <= M_HOLD;
      cnt        <= '0;
      q_out      <= '0;
      ser_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_shift && (amt != '0)) begin
            burst_mode <= mode_e'(mode);
            cnt        <= amt;
            state      <= SHIFT;
            busy       <= 1'b1;
          end else if (start && is_shift) begin
            done <= 1'b1;
          end else if (start || en) begin
            // start with hold/LOAD/reserved behaves as a plain single step.
            q_out   <= q_nxt;
            ser_out <= so_nxt;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            q_out   <= q_nxt;
            ser_out <= so_nxt;
            cnt     <= cnt - AW'(1);
            if (cnt == AW'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
